data_sram_axi_bridge: RTL and testbench
=======================================

# data_sram_axi_bridge

Responder end of the CPU data-side SRAM-like interface (data_req / data_wr / data_size / data_addr / data_wdata) driven by the memory stage. It accepts one request at a time, converts it to a single-beat AXI3 read or write transaction, and returns completion and load data to the pipeline. It sits between the CPU core's memory stage and the AXI interconnect feeding the SoC crossbar.

## Interface
- AXI_ID, 4'h1, ID driven on arid/awid/wid for data-side traffic
- cpu_clk  in  1  core clock; all logic on rising edge
- cpu_rst  in  1  reset, asynchronous, active-high
- data_req  in  1  request valid from memory stage
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- data_addr  in  32  byte address, passed unmodified to AXI
- data_wdata  in  32  store data, already lane-replicated by the memory stage
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  one-cycle completion pulse
- data_rdata  out  32  load data, valid when data_data_ok = 1
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  4/32/4/3/2/2/4/3  AR channel
- arvalid out 1; arready in 1
- rid in 4; rdata in 32; rresp in 2; rlast in 1; rvalid in 1; rready out 1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  out  4/32/4/3/2/2/4/3  AW channel
- awvalid out 1; awready in 1
- wid out 4; wdata out 32; wstrb out 4; wlast out 1; wvalid out 1; wready in 1
- bid in 4; bresp in 2; bvalid in 1; bready out 1

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: data_addr_ok = data_req (combinational). On accept, latch wr, size, addr, wdata, wstrb; go RD_ADDR (load) or WR_REQ (store).
- RD_ADDR: arvalid = 1; on arready go RD_DATA.
- RD_DATA: rready = 1; on rvalid capture rdata into data_rdata, set data_data_ok next cycle, go IDLE.
- WR_REQ: awvalid and wvalid both asserted; aw_done / w_done flags record each handshake independently; each valid drops after its own handshake; when both done (including same cycle) go WR_RESP.
- WR_RESP: bready = 1; on bvalid pulse data_data_ok next cycle, go IDLE.
- Fixed fields: arlen = awlen = 0, arburst = awburst = 2'b01, lock/cache/prot = 0, wlast = 1, ids = AXI_ID, ar/awsize = {1'b0, size} with size 3 mapped to 2.
- wstrb (little-endian lanes): byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
- rresp/bresp/rid/bid ignored; completion returned regardless.
- Reset: FSM to IDLE, all valid/ready/ok outputs 0, data_rdata 0, flags cleared; mid-transaction reset abandons the transaction.

## Timing
- Exactly one outstanding transaction; data_addr_ok is 0 in every non-IDLE state.
- data_data_ok is registered: high for exactly one cycle, the cycle after the R or B handshake; FSM is already IDLE in that cycle, so a new request can be accepted with addr_ok in the same cycle as data_ok.
- Minimum load latency (arready, rvalid immediately high): accept cycle 0, arvalid cycle 1, R handshake cycle 2, data_ok cycle 3.
- Minimum store latency: accept 0, AW+W cycle 1, B cycle 2, data_ok 3.
- AXI valids never drop before handshake; address/data fields stable while valid.

## Structure
- Shared package: FSM state encodings, AXI burst/size constants, AXI_ID default, EXC-independent size codes (SIZE_BYTE/HALF/WORD).
- Sub-module: data_wstrb_gen (size + addr[1:0] -> wstrb), reused by a future uncached instruction-side bridge.

## Test plan
- Word load addr 0x8000_0010, arready/rvalid immediate, rdata 0xDEAD_BEEF -> araddr 0x8000_0010, arsize 2, data_ok cycle 3 with data_rdata 0xDEAD_BEEF.
- Byte store addr 0x...3, wdata 0x5A5A_5A5A -> awsize 0, wstrb 4'b1000, wdata 0x5A5A_5A5A, one data_ok after B.
- Half store addr 0x...2, wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until wready, wstrb 4'b1100, single data_ok.
- Back-to-back load then store with data_req held high -> second addr_ok coincides with first data_ok; no addr_ok while busy.
- rvalid delayed 5 cycles, rresp = 2'b10 -> rready held, data_ok still pulses once with returned rdata.
- cpu_rst asserted while in RD_DATA -> all outputs 0 immediately, IDLE after release, next request handled normally.

Source files
------------

// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared definitions for the data-side SRAM-like to AXI3 bridge: FSM encoding,
// access-size codes and the fixed AXI field values used for single-beat traffic.
package data_sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } bridge_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [3:0] AXI_ID_DEFAULT = 4'h1;

  // Size code 3 is not a legal CPU access; it is issued as a word.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return (size == 2'd3) ? {1'b0, SIZE_WORD} : {1'b0, size};
  endfunction

endpackage

// File: rtl/data_sram_axi_bridge_wstrb.sv
// Byte-lane strobe generator: access size plus the low address bits give the
// little-endian write strobes for a 32-bit bus.
module data_wstrb_gen
  import data_sram_axi_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/data_sram_axi_bridge.sv
// Responder for the CPU data-side SRAM-like port: one request at a time is turned
// into a single-beat AXI3 read or write, and completion is returned as a pulse.
module data_sram_axi_bridge
  import data_sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high. Our valids rise only from state, never wait on ready, and hold
  // with stable payload until their own transfer; our readys are plain state decodes.

  bridge_state_e state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          data_ok_q, data_ok_d;

  logic [3:0] req_wstrb;
  logic       accept;
  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic       aw_done_n, w_done_n, wr_both_done;

  // Responses carry nothing the pipeline consumes; completion is unconditional.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  data_wstrb_gen u_wstrb_gen (
    .size    (data_size),
    .addr_lo (data_addr[1:0]),
    .wstrb   (req_wstrb)
  );

  assign accept       = data_addr_ok;
  assign ar_hs        = arvalid & arready;
  assign r_hs         = rready & rvalid;
  assign aw_hs        = awvalid & awready;
  assign w_hs         = wvalid & wready;
  assign b_hs         = bready & bvalid;
  assign aw_done_n    = aw_done_q | aw_hs;
  assign w_done_n     = w_done_q | w_hs;
  assign wr_both_done = aw_done_n & w_done_n;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = data_wr ? ST_WR_REQ : ST_RD_ADDR;
      end
      ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_hs) state_d = ST_IDLE;
      ST_WR_REQ:  if (wr_both_done) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_addr_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (state_q)
      ST_IDLE:    data_addr_ok = data_req & ~cpu_rst;
      ST_RD_ADDR: arvalid = 1'b1;
      ST_RD_DATA: rready = 1'b1;
      ST_WR_REQ: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
      end
      ST_WR_RESP: bready = 1'b1;
      default:    data_addr_ok = 1'b0;
    endcase
  end

  // Request fields are captured once at accept; load/store direction is held in the state.
  always_comb begin
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    data_ok_d = r_hs | b_hs;
    if (accept) begin
      size_d  = data_size;
      addr_d  = data_addr;
      wdata_d = data_wdata;
      wstrb_d = req_wstrb;
    end
    if (r_hs) rdata_d = rdata;
    if ((state_q == ST_WR_REQ) && !wr_both_done) begin
      aw_done_d = aw_done_n;
      w_done_d  = w_done_n;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      size_q    <= SIZE_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_ok_q <= data_ok_d;
    end
  end

  assign data_data_ok = data_ok_q;
  assign data_rdata   = rdata_q;
  assign dbg_state    = state_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = axi_size(size_q);
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'h0;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = axi_size(size_q);
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'h0;

  assign wid   = AXI_ID;
  assign wdata = wdata_q;
  assign wstrb = wstrb_q;
  assign wlast = 1'b1;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Bench for data_sram_axi_bridge: directed requests against a delay-configurable
// AXI responder, with a scoreboard monitor checking every DUT output event.
module tb_data_sram_axi_bridge;

  logic        cpu_clk, cpu_rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [2:0]  dbg_state;

  data_sram_axi_bridge dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  logic [32:0] exp_q[$];     // {is_load, rdata}
  int          lat_q[$];     // expected accept->data_ok cycles, 0 = not checked
  int          acc_q[$];
  logic [34:0] exp_ar_q[$];  // {araddr, arsize}
  logic [34:0] exp_aw_q[$];  // {awaddr, awsize}
  logic [35:0] exp_w_q[$];   // {wdata, wstrb}

  // ---------------- AXI responder ----------------
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] r_data_cfg = '0;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic        r_hs_s = 1'b0, b_hs_s = 1'b0;

  always @(negedge cpu_clk) begin
    r_hs_s = rvalid && rready;
    b_hs_s = bvalid && bready;
  end

  initial begin : ar_slave
    int cnt;
    cnt = 0; arready = 1'b0;
    forever begin
      @(posedge cpu_clk); #1;
      if (arready) arready = 1'b0;
      else if (arvalid) begin
        if (cnt >= ar_delay) begin arready = 1'b1; cnt = 0; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : aw_slave
    int cnt;
    cnt = 0; awready = 1'b0;
    forever begin
      @(posedge cpu_clk); #1;
      if (awready) awready = 1'b0;
      else if (awvalid) begin
        if (cnt >= aw_delay) begin awready = 1'b1; cnt = 0; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : w_slave
    int cnt;
    cnt = 0; wready = 1'b0;
    forever begin
      @(posedge cpu_clk); #1;
      if (wready) wready = 1'b0;
      else if (wvalid) begin
        if (cnt >= w_delay) begin wready = 1'b1; cnt = 0; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : r_slave
    int cnt;
    cnt = 0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rid = 4'h0; rlast = 1'b0;
    forever begin
      @(posedge cpu_clk); #1;
      if (rvalid) begin
        if (r_hs_s || !rready) begin rvalid = 1'b0; rlast = 1'b0; cnt = 0; end
      end else if (rready) begin
        if (cnt >= r_delay) begin
          rvalid = 1'b1; rdata = r_data_cfg; rresp = r_resp_cfg; rid = 4'h1; rlast = 1'b1;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : b_slave
    int cnt;
    cnt = 0; bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
    forever begin
      @(posedge cpu_clk); #1;
      if (bvalid) begin
        if (b_hs_s || !bready) begin bvalid = 1'b0; cnt = 0; end
      end else if (bready) begin
        if (cnt >= b_delay) begin bvalid = 1'b1; bresp = 2'b00; bid = 4'h1; end
        else cnt++;
      end else cnt = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        busy = 1'b0;
  logic        p_arvalid = 1'b0, p_arready = 1'b0, p_awvalid = 1'b0, p_awready = 1'b0;
  logic        p_wvalid = 1'b0, p_wready = 1'b0;
  logic [34:0] p_ar = '0, p_aw = '0;
  logic [35:0] p_w = '0;
  logic [32:0] m_e;
  int          m_l, m_a;
  logic [34:0] m_x;
  logic [35:0] m_w;

  always @(negedge cpu_clk) begin
    if (cpu_rst) begin
      busy = 1'b0;
      p_arvalid = 1'b0; p_awvalid = 1'b0; p_wvalid = 1'b0;
      p_arready = 1'b0; p_awready = 1'b0; p_wready = 1'b0;
    end else begin
      if (busy && !data_data_ok) chk("no_addr_ok_busy", 64'(data_addr_ok), 64'(0));

      if (p_arvalid && !p_arready)
        chk("ar_stable", 64'({arvalid, araddr, arsize}), 64'({1'b1, p_ar}));
      if (p_arvalid && p_arready) chk("ar_drop", 64'(arvalid), 64'(0));
      if (p_awvalid && !p_awready)
        chk("aw_stable", 64'({awvalid, awaddr, awsize}), 64'({1'b1, p_aw}));
      if (p_awvalid && p_awready) chk("aw_drop", 64'(awvalid), 64'(0));
      if (p_wvalid && !p_wready)
        chk("w_stable", 64'({wvalid, wdata, wstrb}), 64'({1'b1, p_w}));
      if (p_wvalid && p_wready) chk("w_drop", 64'(wvalid), 64'(0));

      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) chk("spurious_ar", 64'(arvalid), 64'(0));
        else begin
          m_x = exp_ar_q.pop_front();
          chk("ar_addr_size", 64'({araddr, arsize}), 64'(m_x));
          chk("ar_fixed", 64'({arid, arlen, arburst, arlock, arcache, arprot}),
              64'({4'h1, 4'h0, 2'b01, 2'b00, 4'h0, 3'h0}));
        end
      end
      if (awvalid && awready) begin
        if (exp_aw_q.size() == 0) chk("spurious_aw", 64'(awvalid), 64'(0));
        else begin
          m_x = exp_aw_q.pop_front();
          chk("aw_addr_size", 64'({awaddr, awsize}), 64'(m_x));
          chk("aw_fixed", 64'({awid, awlen, awburst, awlock, awcache, awprot}),
              64'({4'h1, 4'h0, 2'b01, 2'b00, 4'h0, 3'h0}));
        end
      end
      if (wvalid && wready) begin
        if (exp_w_q.size() == 0) chk("spurious_w", 64'(wvalid), 64'(0));
        else begin
          m_w = exp_w_q.pop_front();
          chk("w_data_strb", 64'({wdata, wstrb}), 64'(m_w));
          chk("w_fixed", 64'({wid, wlast}), 64'({4'h1, 1'b1}));
        end
      end

      if (data_data_ok) begin
        if (exp_q.size() == 0) chk("spurious_data_ok", 64'(data_data_ok), 64'(0));
        else begin
          m_e = exp_q.pop_front();
          m_l = lat_q.pop_front();
          m_a = acc_q.pop_front();
          if (m_e[32]) chk("load_rdata", 64'(data_rdata), 64'(m_e[31:0]));
          if (m_l != 0) chk("latency", 64'(cyc - m_a), 64'(m_l));
        end
        busy = 1'b0;
      end
      if (data_req && data_addr_ok) busy = 1'b1;

      p_arvalid = arvalid; p_arready = arready; p_ar = {araddr, arsize};
      p_awvalid = awvalid; p_awready = awready; p_aw = {awaddr, awsize};
      p_wvalid  = wvalid;  p_wready  = wready;  p_w  = {wdata, wstrb};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rdata,
                       input logic [2:0] exp_axsize, input logic [3:0] exp_wstrb,
                       input int exp_lat, input logic with_ok);
    int budget;
    budget = 0;
    data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    #1;
    while (!data_addr_ok && budget < 100) begin
      @(posedge cpu_clk); #2;
      budget++;
    end
    chk("accept", 64'(data_addr_ok), 64'(1));
    if (data_addr_ok) begin
      if (with_ok) chk("addr_ok_with_data_ok", 64'(data_data_ok), 64'(1));
      exp_q.push_back({!wr, exp_rdata});
      lat_q.push_back(exp_lat);
      acc_q.push_back(cyc);
      if (wr) begin
        exp_aw_q.push_back({addr, exp_axsize});
        exp_w_q.push_back({wd, exp_wstrb});
      end else begin
        exp_ar_q.push_back({addr, exp_axsize});
      end
    end
    @(posedge cpu_clk); #1;
    data_req = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge cpu_clk); #1;
      budget++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({data_addr_ok, data_data_ok, arvalid, rready, awvalid, wvalid, bready}),
        64'(0));
    chk({tag, "_rdata"}, 64'(data_rdata), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cpu_rst = 1'b1;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    repeat (2) @(posedge cpu_clk);
    #1;
    chk_outputs_zero("reset");
    chk("reset_state", 64'(dbg_state), 64'(0));
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    @(posedge cpu_clk); #1;

    // Word load, zero-wait responder: data_ok three cycles after accept.
    r_data_cfg = 32'hDEAD_BEEF;
    issue(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 3'd2, 4'h0, 3, 1'b0);
    drain();

    // Byte store to lane 3.
    issue(1'b1, 2'd0, 32'h8000_0023, 32'h5A5A_5A5A, 32'h0, 3'd0, 4'b1000, 3, 1'b0);
    drain();

    // Half store, upper half, wready three cycles after awready.
    w_delay = 3;
    issue(1'b1, 2'd1, 32'h8000_0102, 32'hBEEF_BEEF, 32'h0, 3'd1, 4'b1100, 6, 1'b0);
    drain();
    w_delay = 0;

    // Back-to-back load then store (size 3 issued as word).
    r_data_cfg = 32'h0BAD_F00D;
    issue(1'b0, 2'd2, 32'h8000_0200, 32'h0, 32'h0BAD_F00D, 3'd2, 4'h0, 3, 1'b0);
    issue(1'b1, 2'd3, 32'h8000_0204, 32'h1122_3344, 32'h0, 3'd2, 4'b1111, 3, 1'b1);
    drain();

    // Half load, rvalid late and SLVERR response: completion still returned.
    r_delay = 5; r_resp_cfg = 2'b10; r_data_cfg = 32'hCAFE_F00D;
    issue(1'b0, 2'd1, 32'h8000_0302, 32'h0, 32'hCAFE_F00D, 3'd1, 4'h0, 8, 1'b0);
    drain();
    r_delay = 0; r_resp_cfg = 2'b00;

    // Byte store lane 1 with awready late: W completes first.
    aw_delay = 2;
    issue(1'b1, 2'd0, 32'h8000_0401, 32'h7777_7777, 32'h0, 3'd0, 4'b0010, 5, 1'b0);
    drain();
    aw_delay = 0;

    // Half store, lower half.
    issue(1'b1, 2'd1, 32'h8000_0410, 32'h9999_9999, 32'h0, 3'd1, 4'b0011, 3, 1'b0);
    drain();

    // Reset while waiting in RD_DATA abandons the load.
    r_delay = 20; r_data_cfg = 32'h5555_AAAA;
    issue(1'b0, 2'd2, 32'h8000_0500, 32'h0, 32'h0, 3'd2, 4'h0, 0, 1'b0);
    @(posedge cpu_clk); #1;
    @(posedge cpu_clk); #1;
    chk("pre_reset_rready", 64'(rready), 64'(1));
    #2;
    cpu_rst = 1'b1;
    #1;
    chk_outputs_zero("mid_reset");
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
    @(posedge cpu_clk); #1;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    r_delay = 0;
    @(posedge cpu_clk); #1;
    chk("idle_after_reset", 64'(dbg_state), 64'(0));

    r_data_cfg = 32'h1234_5678;
    issue(1'b0, 2'd2, 32'h8000_0600, 32'h0, 32'h1234_5678, 3'd2, 4'h0, 3, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
